mod_counter: RTL



---
 rtl/mod_counter_if.sv | 61 ++++++
 rtl/mod_counter.sv | 114 +++++++++++
 2 files changed

// File: rtl/mod_counter_if.sv
// mod_counter_if
// ----------------------------------------------------------------------------
// Control and status bundle for one mod_counter digit. The clock and reset
// stay outside the bundle so several digits can share them directly.
//
// Signals (direction as seen by the counter, i.e. the slave modport):
//   Enable     in   count enable; tie high or drive from a lower CarryOut
//   Direction  in   0 = count up, 1 = count down
//   Hold       in   1 = freeze the count (Load still takes effect)
//   Load       in   synchronous parallel load strobe
//   LoadValue  in   value to load, clamped to MODULUS-1
//   Mode       in   0 = wrap, 1 = one-shot (stop at the terminal value)
//   A          out  current count
//   Overflow   out  registered one-cycle pulse after a wrap
//   CarryOut   out  combinational, high when the next edge wraps
//   Done       out  sticky one-shot terminal flag
// ----------------------------------------------------------------------------
interface mod_counter_if #(
  parameter int WIDTH = 4
);

  logic             Enable;
  logic             Direction;
  logic             Hold;
  logic             Load;
  logic [WIDTH-1:0] LoadValue;
  logic             Mode;
  logic [WIDTH-1:0] A;
  logic             Overflow;
  logic             CarryOut;
  logic             Done;

  // The side that controls the digit (a bench, a sequencer, a lower digit).
  modport master (
    output Enable,
    output Direction,
    output Hold,
    output Load,
    output LoadValue,
    output Mode,
    input  A,
    input  Overflow,
    input  CarryOut,
    input  Done
  );

  // The counter digit itself.
  modport slave (
    input  Enable,
    input  Direction,
    input  Hold,
    input  Load,
    input  LoadValue,
    input  Mode,
    output A,
    output Overflow,
    output CarryOut,
    output Done
  );

endinterface

// File: rtl/mod_counter.sv
// mod_counter
// ----------------------------------------------------------------------------
// Parametrised modulo-N up/down digit counter. Counts 0..MODULUS-1 in either
// direction with hold, synchronous parallel load and a wrap or one-shot mode.
// CarryOut is combinational so a chain of digits sharing one clock steps on
// the same edge the lower digit wraps. Overflow is a registered one-cycle
// pulse for consumers that expect the older fixed mod-6 digit behaviour.
//
// Parameters:
//   WIDTH        counter width in bits
//   MODULUS      count modulus, 2..2^WIDTH
//   RESET_VALUE  count after reset, below MODULUS
//
// Ports:
//   Clock        rising-edge clock
//   Reset        asynchronous, active-low reset
//   bus          mod_counter_if slave modport (controls in, count/status out)
// ----------------------------------------------------------------------------
module mod_counter #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 6,
  parameter int RESET_VALUE = 5
) (
  input  logic         Clock,
  input  logic         Reset,
  mod_counter_if.slave bus
);

  // Largest legal count and reset value at the counter width.
  localparam logic [WIDTH-1:0] MaxCount   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ResetCount = WIDTH'(RESET_VALUE);

  // One extra bit so MODULUS = 2^WIDTH still compares correctly.
  localparam logic [WIDTH:0]   ModulusWide = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             done_q;
  logic             done_d;

  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] loadClamped;
  logic [WIDTH-1:0] wrapTarget;
  logic [WIDTH-1:0] stepTarget;
  logic [WIDTH:0]   loadWide;
  logic             atTerminal;
  logic             stepEn;

  // Terminal value and wrap target both follow Direction combinationally,
  // so a direction change takes effect on the very next edge.
  always_comb begin
    terminal   = bus.Direction ? '0 : MaxCount;
    wrapTarget = bus.Direction ? MaxCount : '0;
    stepTarget = bus.Direction ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
    atTerminal = (count_q == terminal);
    stepEn     = bus.Enable & ~bus.Hold & ~bus.Load;
  end

  // Out-of-range load values saturate at the top count, so the register can
  // never hold an illegal value.
  always_comb begin
    loadWide = {1'b0, bus.LoadValue};
    if (loadWide >= ModulusWide) begin
      loadClamped = MaxCount;
    end else begin
      loadClamped = bus.LoadValue;
    end
  end

  // Next-state: Load beats Hold beats a step. Done is sticky only while in
  // one-shot mode; any edge with Mode=0 clears it.
  always_comb begin
    count_d    = count_q;
    overflow_d = 1'b0;
    done_d     = bus.Mode ? done_q : 1'b0;

    if (bus.Load) begin
      count_d = loadClamped;
      done_d  = 1'b0;
    end else if (stepEn) begin
      if (!atTerminal) begin
        count_d = stepTarget;
      end else if (!bus.Mode) begin
        count_d    = wrapTarget;
        overflow_d = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end
  end

  // State registers; reset discards the count and any pending Overflow.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_q    <= ResetCount;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // CarryOut is the wrap decision itself, so an upper digit enabled by it
  // steps on the same edge this digit wraps. No carry in one-shot mode.
  assign bus.CarryOut = stepEn & ~bus.Mode & atTerminal;
  assign bus.A        = count_q;
  assign bus.Overflow = overflow_q;
  assign bus.Done     = done_q;

endmodule
